// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding and default width for the repeated-add multiplier
package mul_pkg;

    localparam int MUL_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_B,
        ADD,
        DONE
    } state_t;

endpackage

// File: rtl/acc_reg.sv
// rtl/acc_reg.sv - W-bit accumulator with synchronous clear, add-enable and carry-out
module acc_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         add_en,
    input  logic [W-1:0] addend,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] acc;
    logic [W:0]   full;

    // sum/cout are the value the accumulator takes on this add, so the owner
    // can capture the final result on the same edge the last add lands.
    assign full = {1'b0, acc} + {1'b0, addend};
    assign sum  = full[W-1:0];
    assign cout = full[W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/repadd_mul_seq.sv
// rtl/repadd_mul_seq.sv - unsigned multiply by repeated addition with shared operand bus
module repadd_mul_seq
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] din,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product,
    output logic         overflow
);

    state_t       state, nxt;
    logic [W-1:0] a_reg;
    logic [W-1:0] cnt;
    logic         carry_q;
    logic         acc_clr;
    logic         add_en;
    logic [W-1:0] sum;
    logic         cout;
    logic         a_load;

    acc_reg #(.W(W)) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .add_en (add_en),
        .addend (a_reg),
        .sum    (sum),
        .cout   (cout)
    );

    assign a_load = start && (state == IDLE || state == DONE);

    always_comb begin
        nxt     = state;
        acc_clr = 1'b0;
        add_en  = 1'b0;
        case (state)
            IDLE:   if (start) nxt = LOAD_B;
            LOAD_B: begin
                acc_clr = 1'b1;
                nxt     = (din == '0) ? DONE : ADD;
            end
            ADD: begin
                add_en = 1'b1;
                if (cnt == W'(1)) nxt = DONE;
            end
            DONE:   nxt = start ? LOAD_B : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
        end else begin
            if (a_load) a_reg <= din;
            if (state == LOAD_B) begin
                cnt     <= din;
                carry_q <= 1'b0;
            end else if (state == ADD) begin
                cnt     <= cnt - W'(1);
                carry_q <= carry_q | cout;
            end
        end
    end

    // Result is captured on the edge that enters DONE so it is already
    // stable while done is high; B=0 arrives from LOAD_B with a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (nxt == DONE && state != DONE) begin
                product  <= (state == ADD) ? sum : '0;
                overflow <= (state == ADD) ? (carry_q | cout) : 1'b0;
            end
            busy <= (nxt == LOAD_B) || (nxt == ADD);
            done <= (nxt == DONE);
        end
    end

endmodule

// File: tb/tb_repadd_mul_seq.sv
// tb/tb_repadd_mul_seq.sv - directed self-checking bench for repadd_mul_seq
module tb_repadd_mul_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] din;
    logic         busy;
    logic         done;
    logic [W-1:0] product;
    logic         overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] last_prod = '0;

    repadd_mul_seq #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after an edge with the DUT in IDLE or DONE;
    // returns 1 time unit after the edge that raised done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_p, input logic exp_o,
                          input int pulse_cycle);
        int c;
        start = 1'b1;
        din   = a;
        step();
        c     = 1;
        start = 1'b0;
        din   = b;
        check("busy_load_b", busy, 1);
        check("done_load_b", done, 0);
        step();
        c   = 2;
        din = 16'hBEEF;
        while (!done && c < int'(b) + 10) begin
            check("busy_run", busy, 1);
            check("prod_hold", product, last_prod);
            if (c == pulse_cycle) begin
                start = 1'b1;
                din   = 16'd77;
            end else begin
                start = 1'b0;
                din   = 16'hBEEF;
            end
            step();
            c++;
        end
        start = 1'b0;
        check("latency", c, int'(b) + 2);
        check("done", done, 1);
        check("busy_done", busy, 0);
        check("product", product, exp_p);
        check("overflow", overflow, exp_o);
        last_prod = exp_p;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        check("rst_overflow", overflow, 0);
        step();
        rst_n = 1'b1;
        step();

        run_op(16'd5, 16'd3, 16'd15, 1'b0, 0);
        step();
        check("done_strobe", done, 0);
        check("prod_after", product, 15);

        run_op(16'd7, 16'd0, 16'd0, 1'b0, 0);
        step();
        run_op(16'd0, 16'd4, 16'd0, 1'b0, 0);
        step();
        run_op(16'd300, 16'd300, 16'd24464, 1'b1, 0);
        step();
        run_op(16'd256, 16'd256, 16'd0, 1'b1, 0);
        step();
        run_op(16'd65535, 16'd1, 16'd65535, 1'b0, 0);
        step();

        // start pulse during ADD is ignored, then back-to-back from DONE
        run_op(16'd5, 16'd3, 16'd15, 1'b0, 3);
        run_op(16'd2, 16'd2, 16'd4, 1'b0, 0);
        step();

        // 9x6 with reset asserted in the second ADD cycle
        start = 1'b1;
        din   = 16'd9;
        step();
        start = 1'b0;
        din   = 16'd6;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_product", product, 0);
        check("midrst_overflow", overflow, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_hold_done", done, 0);
        end
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            check("no_done_after_rst", done, 0);
            step();
        end
        last_prod = '0;
        run_op(16'd3, 16'd3, 16'd9, 1'b0, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
